// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, a one-entry skid buffer
// and synchronous flush; control fields are zeroed on every empty slot.
module ex_mem_pipe #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic [REG_W-1:0]  RegDst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] ALUresult_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [REG_W-1:0]  RegDst_o
);

  logic              skid_valid;
  logic [WB_W-1:0]   skid_wb;
  logic [M_W-1:0]    skid_m;
  logic [DATA_W-1:0] skid_alu;
  logic [DATA_W-1:0] skid_wd;
  logic [REG_W-1:0]  skid_rd;

  logic acc;
  logic load_main;

  // Ready comes straight from a flop, so no input reaches it combinationally.
  assign in_ready_o = ~skid_valid;
  assign acc        = in_valid_i & in_ready_o & ~flush_i;
  assign load_main  = ~out_valid_o | out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      WB_o        <= '0;
      M_o         <= '0;
      ALUresult_o <= '0;
      WriteData_o <= '0;
      RegDst_o    <= '0;
      skid_valid  <= 1'b0;
      skid_wb     <= '0;
      skid_m      <= '0;
      skid_alu    <= '0;
      skid_wd     <= '0;
      skid_rd     <= '0;
    end else if (flush_i) begin
      // Data fields keep their last value; only the control side is squashed.
      out_valid_o <= 1'b0;
      skid_valid  <= 1'b0;
      WB_o        <= '0;
      M_o         <= '0;
    end else if (load_main) begin
      if (skid_valid) begin
        out_valid_o <= 1'b1;
        WB_o        <= skid_wb;
        M_o         <= skid_m;
        ALUresult_o <= skid_alu;
        WriteData_o <= skid_wd;
        RegDst_o    <= skid_rd;
        skid_valid  <= acc;
        if (acc) begin
          skid_wb  <= WB_i;
          skid_m   <= M_i;
          skid_alu <= ALUresult_i;
          skid_wd  <= WriteData_i;
          skid_rd  <= RegDst_i;
        end
      end else if (acc) begin
        out_valid_o <= 1'b1;
        WB_o        <= WB_i;
        M_o         <= M_i;
        ALUresult_o <= ALUresult_i;
        WriteData_o <= WriteData_i;
        RegDst_o    <= RegDst_i;
      end else begin
        out_valid_o <= 1'b0;
        WB_o        <= '0;
        M_o         <= '0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_wb    <= WB_i;
      skid_m     <= M_i;
      skid_alu   <= ALUresult_i;
      skid_wd    <= WriteData_i;
      skid_rd    <= RegDst_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a default-width and a wide instance share
// handshake stimulus; accepted entries are queued and checked as they drain.
module tb_ex_mem_pipe;

  typedef struct {
    logic [2:0]  wb;
    logic [1:0]  m;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [5:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [2:0]  d_wb = '0;
  logic [1:0]  d_m = '0;
  logic [63:0] d_alu = '0;
  logic [63:0] d_wd = '0;
  logic [5:0]  d_rd = '0;

  logic        n_in_ready, n_out_valid;
  logic [1:0]  n_wb, n_m;
  logic [31:0] n_alu, n_wd;
  logic [4:0]  n_rd;

  logic        w_in_ready, w_out_valid;
  logic [2:0]  w_wb;
  logic [1:0]  w_m;
  logic [63:0] w_alu, w_wd;
  logic [5:0]  w_rd;

  int total = 0;
  int bad = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_pipe u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .WB_i(d_wb[1:0]), .M_i(d_m), .ALUresult_i(d_alu[31:0]),
    .WriteData_i(d_wd[31:0]), .RegDst_i(d_rd[4:0]),
    .out_valid_o(n_out_valid), .out_ready_i(out_ready),
    .WB_o(n_wb), .M_o(n_m), .ALUresult_o(n_alu),
    .WriteData_o(n_wd), .RegDst_o(n_rd)
  );

  ex_mem_pipe #(.WB_W(3), .M_W(2), .DATA_W(64), .REG_W(6)) u_wide (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(w_in_ready),
    .WB_i(d_wb), .M_i(d_m), .ALUresult_i(d_alu),
    .WriteData_i(d_wd), .RegDst_i(d_rd),
    .out_valid_o(w_out_valid), .out_ready_i(out_ready),
    .WB_o(w_wb), .M_o(w_m), .ALUresult_o(w_alu),
    .WriteData_o(w_wd), .RegDst_o(w_rd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [31:0] wd,
                              input logic [5:0] rd, input logic [2:0] wb, input logic [1:0] m);
    ent_t e;
    e.alu = {~alu, alu};
    e.wd  = {wd ^ 32'h5555_AAAA, wd};
    e.rd  = rd;
    e.wb  = wb;
    e.m   = m;
    return e;
  endfunction

  // Monitor: pops and compares every drained entry, and checks bubble gating.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wide_valid_track", {63'd0, w_out_valid}, {63'd0, n_out_valid});
      if (!n_out_valid) begin
        chk("bubble_wb", {62'd0, n_wb}, 64'd0);
        chk("bubble_m", {62'd0, n_m}, 64'd0);
      end
      if (!w_out_valid) begin
        chk("wide_bubble_wb", {61'd0, w_wb}, 64'd0);
        chk("wide_bubble_m", {62'd0, w_m}, 64'd0);
      end
      if (n_out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", {32'd0, n_alu}, 64'd0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("n_alu", {32'd0, n_alu}, {32'd0, e.alu[31:0]});
          chk("n_wd", {32'd0, n_wd}, {32'd0, e.wd[31:0]});
          chk("n_rd", {59'd0, n_rd}, {59'd0, e.rd[4:0]});
          chk("n_wb", {62'd0, n_wb}, {62'd0, e.wb[1:0]});
          chk("n_m", {62'd0, n_m}, {62'd0, e.m});
          chk("w_alu", w_alu, e.alu);
          chk("w_wd", w_wd, e.wd);
          chk("w_rd", {58'd0, w_rd}, {58'd0, e.rd});
          chk("w_wb", {61'd0, w_wb}, {61'd0, e.wb});
        end
      end
    end
  end

  task automatic cyc(input logic v, input ent_t e, input logic rdy, input logic fl);
    in_valid  = v;
    d_wb      = e.wb;
    d_m       = e.m;
    d_alu     = e.alu;
    d_wd      = e.wd;
    d_rd      = e.rd;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    if (fl) exp_q.delete();
    else if (v && n_in_ready && !rst) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic valid, input logic ready,
                           input logic [31:0] alu);
    chk({name, "_valid"}, {63'd0, n_out_valid}, {63'd0, valid});
    chk({name, "_ready"}, {63'd0, n_in_ready}, {63'd0, ready});
    chk({name, "_wready"}, {63'd0, w_in_ready}, {63'd0, ready});
    if (valid) chk({name, "_alu"}, {32'd0, n_alu}, {32'd0, alu});
  endtask

  ent_t idle;
  ent_t e;

  initial begin
    idle = mk(32'h0, 32'h0, 6'h0, 3'b000, 2'b00);

    // Reset with every input held high.
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    d_wb = '1; d_m = '1; d_alu = '1; d_wd = '1; d_rd = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", {63'd0, n_out_valid}, 64'd0);
    chk("rst_ready", {63'd0, n_in_ready}, 64'd1);
    chk("rst_wb", {62'd0, n_wb}, 64'd0);
    chk("rst_m", {62'd0, n_m}, 64'd0);
    chk("rst_alu", {32'd0, n_alu}, 64'd0);
    chk("rst_wd", {32'd0, n_wd}, 64'd0);
    chk("rst_rd", {59'd0, n_rd}, 64'd0);
    chk("rst_w_alu", w_alu, 64'd0);
    chk("rst_w_wd", w_wd, 64'd0);
    chk("rst_w_valid", {63'd0, w_out_valid}, 64'd0);
    rst = 1'b0;
    cyc(1'b0, idle, 1'b1, 1'b0);
    chk_state("post_rst", 1'b0, 1'b1, 32'h0);

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) begin
      e = mk(32'h10 + i, 32'h100 + i, 6'(i + 1), 3'b011, 2'b00);
      cyc(1'b1, e, 1'b1, 1'b0);
      chk_state("stream", 1'b1, 1'b1, 32'h10 + i);
      chk("stream_rd", {59'd0, n_rd}, 64'(i + 1));
    end
    cyc(1'b0, idle, 1'b1, 1'b0);
    chk_state("stream_end", 1'b0, 1'b1, 32'h0);

    // Backpressure: four stall cycles while 0xA0..0xA2 are offered.
    e = mk(32'hA0, 32'hB0, 6'h01, 3'b001, 2'b10);
    cyc(1'b1, e, 1'b0, 1'b0);
    chk_state("bp_c0", 1'b1, 1'b1, 32'hA0);
    e = mk(32'hA1, 32'hCAFEF00D, 6'h25, 3'b110, 2'b01);
    e.wd = 64'hDEADBEEF_CAFEF00D;
    e.alu = 64'hDEADBEEF_CAFEF00D;
    e.alu[31:0] = 32'hA1;
    cyc(1'b1, e, 1'b0, 1'b0);
    chk_state("bp_c1", 1'b1, 1'b0, 32'hA0);
    e = mk(32'hA2, 32'hB2, 6'h03, 3'b010, 2'b11);
    cyc(1'b1, e, 1'b0, 1'b0);
    chk_state("bp_c2", 1'b1, 1'b0, 32'hA0);
    cyc(1'b1, e, 1'b0, 1'b0);
    chk_state("bp_c3", 1'b1, 1'b0, 32'hA0);
    cyc(1'b1, e, 1'b1, 1'b0);
    chk_state("bp_rel0", 1'b1, 1'b1, 32'hA1);
    chk("bp_wide_wd", w_wd, 64'hDEADBEEF_CAFEF00D);
    chk("bp_wide_rd", {58'd0, w_rd}, 64'h25);
    chk("bp_wide_wb", {61'd0, w_wb}, 64'h6);
    cyc(1'b1, e, 1'b1, 1'b0);
    chk_state("bp_rel1", 1'b1, 1'b1, 32'hA2);
    cyc(1'b0, idle, 1'b1, 1'b0);
    chk_state("bp_end", 1'b0, 1'b1, 32'h0);

    // Flush with main and skid full and a third entry on the input.
    cyc(1'b1, mk(32'hF0, 32'hE0, 6'h0A, 3'b111, 2'b11), 1'b0, 1'b0);
    cyc(1'b1, mk(32'hF1, 32'hE1, 6'h0B, 3'b101, 2'b10), 1'b0, 1'b0);
    chk_state("fl_full", 1'b1, 1'b0, 32'hF0);
    cyc(1'b1, mk(32'hF2, 32'hE2, 6'h0C, 3'b011, 2'b01), 1'b0, 1'b1);
    chk_state("fl_after", 1'b0, 1'b1, 32'h0);
    chk("fl_wb", {62'd0, n_wb}, 64'd0);
    chk("fl_m", {62'd0, n_m}, 64'd0);
    chk("fl_hold_alu", {32'd0, n_alu}, 64'hF0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, idle, 1'b1, 1'b0);
      chk_state("fl_idle", 1'b0, 1'b1, 32'h0);
    end

    // Bubble gating: control still presented on the input between entries.
    for (int i = 0; i < 3; i++) begin
      e = mk(32'hC0 + i, 32'hD0 + i, 6'(16 + i), 3'b011, 2'b01);
      cyc(1'b1, e, 1'b1, 1'b0);
      chk_state("gate_ent", 1'b1, 1'b1, 32'hC0 + i);
      cyc(1'b0, e, 1'b1, 1'b0);
      chk_state("gate_bub", 1'b0, 1'b1, 32'h0);
      chk("gate_m", {62'd0, n_m}, 64'd0);
      chk("gate_wb", {62'd0, n_wb}, 64'd0);
      chk("gate_hold_alu", {32'd0, n_alu}, {32'd0, 32'hC0 + i});
    end

    // Reset mid-stall discards both slots.
    cyc(1'b1, mk(32'h70, 32'h71, 6'h07, 3'b001, 2'b01), 1'b0, 1'b0);
    cyc(1'b1, mk(32'h72, 32'h73, 6'h08, 3'b010, 2'b10), 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_state("rst_stall", 1'b0, 1'b1, 32'h0);
    cyc(1'b0, idle, 1'b1, 1'b0);
    cyc(1'b0, idle, 1'b1, 1'b0);
    chk_state("rst_stall_idle", 1'b0, 1'b1, 32'h0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage with valid/ready flow control, a one-entry skid buffer and a synchronous flush. It replaces the fixed-width, always-advancing EX/MEM latch. Downstream MEM backpressure (for example a multi-cycle data cache) stalls the stage without combinational ready paths crossing it. Control fields are forced to zero on every bubble, so squashed or empty slots never write memory or the register file.

## Interface
Parameters:
- WB_W, 2, width of write-back control field
- M_W, 2, width of memory control field
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, width of destination register index

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  squash all held and incoming entries this cycle
- in_valid_i  in  1  EX presents an entry
- in_ready_o  out  1  stage can accept an entry; registered (equals !skid_valid)
- WB_i  in  WB_W  write-back control
- M_i  in  M_W  memory control
- ALUresult_i  in  DATA_W  ALU result
- WriteData_i  in  DATA_W  store data
- RegDst_i  in  REG_W  destination register
- out_valid_o  out  1  MEM-side entry valid
- out_ready_i  in  1  MEM consumes the entry this cycle
- WB_o, M_o, ALUresult_o, WriteData_o, RegDst_o  out  widths as inputs  registered entry fields

## Operation
- Storage is two slots:
  - main (drives outputs), tracked by out_valid_o
  - skid, tracked by internal skid_valid
- Accept: acc = in_valid_i & in_ready_o & !flush_i.
- Drain: drn = out_valid_o & out_ready_i.
- Main load condition: !out_valid_o | out_ready_i.
  - If skid_valid: main ← skid, skid_valid ← 0. If acc also occurs, the input goes to skid, so skid_valid stays 1.
  - Else if acc: main ← input.
  - Else: out_valid_o ← 0 and WB_o/M_o ← 0 (bubble).
- Main not loadable (valid and !out_ready_i) with acc: input goes to skid and skid_valid ← 1. acc is impossible while skid_valid=1 because in_ready_o=0.
- Order is preserved: entries leave in the order they were accepted.
- Flush (priority over everything except reset):
  - out_valid_o ← 0, skid_valid ← 0, WB_o ← 0, M_o ← 0.
  - The input presented that cycle is dropped.
  - ALUresult_o/WriteData_o/RegDst_o hold their values.
- Invariant: out_valid_o=0 implies WB_o=0 and M_o=0.
- Data fields of an invalid slot are don't-care, but deterministic: hold the last loaded value.
- No arithmetic; all fields pass through bit-exact at the parameter widths.

## Timing
- Reset (rst_i=1 at an edge):
  - out_valid_o=0, skid_valid=0, so in_ready_o=1 after the edge.
  - WB_o, M_o, ALUresult_o, WriteData_o and RegDst_o all zero.
- Reset overrides flush and all handshakes. Reset asserted mid-stall discards both slots.
- Latency: an entry accepted at edge N appears on outputs after edge N, with out_valid_o=1 in cycle N+1 when the stage is unstalled.
- Throughput: 1 entry per cycle with out_ready_i held at 1. in_ready_o stays 1 and the skid stays unused.
- Stall: out_ready_i=0 with main valid.
  - The first accepted entry is captured in skid.
  - in_ready_o drops the cycle after capture.
- Release: the first cycle with out_ready_i=1:
  - the held main drains;
  - skid moves to main;
  - in_ready_o rises the following cycle.
- Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous flush with out_ready_i=1: the main entry is treated as consumed that cycle. The entry being accepted that cycle is dropped.
- in_ready_o and out_valid_o have no combinational path from any input.

## Test plan
- Reset with all inputs at 1:
  - after the edge, every output is 0 and in_ready_o=1;
  - releasing reset with in_valid_i=0 leaves out_valid_o=0.
- Streaming 8 entries (ALUresult_i=0x10..0x17, RegDst_i=1..8, WB_i=2'b11) with out_ready_i=1:
  - each entry appears exactly one cycle later, in order;
  - in_ready_o never drops.
- Backpressure:
  - Stimulus: out_ready_i=0 for 4 cycles while streaming 0xA0, 0xA1, 0xA2.
  - Outputs hold 0xA0.
  - 0xA1 is captured in skid; in_ready_o=0 from the next cycle, so 0xA2 waits at the input.
  - After release, outputs show 0xA0, 0xA1, 0xA2 on consecutive cycles with no loss or duplication.
- Flush:
  - Stimulus: flush_i for one cycle while main and skid are both full and in_valid_i=1.
  - Next cycle: out_valid_o=0, WB_o=0, M_o=0, in_ready_o=1.
  - The three entries never appear at the output.
- Bubble gating: in_valid_i=0 between entries with M_i=2'b01 held on the input forces M_o=0 and WB_o=0 in every invalid cycle.
- Parameter sweep with DATA_W=64, REG_W=6, WB_W=3: pattern 0xDEADBEEF_CAFEF00D passes through bit-exact, with skid capture exercised.
